urp_pcie_tx_arbiter: RTL and testbench
======================================

URP_PCIE_TX_ARBITER -- requirements
Module: urp_pcie_tx_arbiter

Interface
REQ-001 Parameter PH_CREDITS, default 8: posted-header credits granted by the link partner at init, range 1..255.
REQ-002 Parameter NPH_CREDITS, default 8: non-posted-header credits at init, range 1..255.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 p_tlp_i  input  224  posted TLP (MWr) from the posted FIFO.
REQ-006 p_valid_i  input  1  posted TLP available.
REQ-007 p_ready_o  output  1  posted TLP consumed this cycle.
REQ-008 np_tlp_i  input  224  non-posted TLP (MRd) from the non-posted FIFO.
REQ-009 np_valid_i  input  1  non-posted TLP available.
REQ-010 np_ready_o  output  1  non-posted TLP consumed this cycle.
REQ-011 ph_ret_i  input  1  one posted-header credit returned (1-cycle pulse).
REQ-012 nph_ret_i  input  1  one non-posted-header credit returned (1-cycle pulse).
REQ-013 tlp_o  output  224  arbitrated TLP to the data link layer.
REQ-014 tlp_valid_o  output  1  tlp_o valid.
REQ-015 tlp_ready_i  input  1  data link layer accepts tlp_o.
REQ-016 tlp_src_o  output  1  source of tlp_o: 0 = posted, 1 = non-posted.
REQ-017 ph_cnt_o, nph_cnt_o  output  8 each  current available credits.
REQ-018 cred_err_o  output  1  sticky: credit returned while counter at init value.

Function
REQ-019 Eligibility: P eligible = p_valid_i && ph_cnt != 0; NP eligible = np_valid_i && nph_cnt != 0.
REQ-020 Output register states: EMPTY (tlp_valid_o=0) and FULL (tlp_valid_o=1).
REQ-021 Load permitted when state is EMPTY, or FULL with tlp_ready_i=1 (back-to-back, no bubble).
REQ-022 On load with at least one eligible source, grant exactly one; its ready output is 1 combinationally in that cycle, the other 0.
REQ-023 Both eligible: grant the source not granted last (round-robin); last-grant pointer resets to NP, so P wins the first tie.
REQ-024 One eligible: grant it regardless of the pointer; the pointer updates only on a grant.
REQ-025 Granted TLP and source appear on tlp_o/tlp_src_o the cycle after the grant with tlp_valid_o=1 (latency 1).
REQ-026 FULL with tlp_ready_i=1 and nothing eligible: next state EMPTY.
REQ-027 FULL with tlp_ready_i=0: tlp_o, tlp_src_o, tlp_valid_o held stable; p_ready_o=np_ready_o=0.
REQ-028 p_ready_o/np_ready_o never asserted for an ineligible source; no grant while a credit counter is 0 for that class.
REQ-029 Credit counter: grant decrements by 1; return pulse increments by 1; grant and return in the same cycle leave it unchanged.
REQ-030 Return while counter equals its init value and no same-cycle grant: counter unchanged, cred_err_o set, cleared only by reset.
REQ-031 ph_ret_i and nph_ret_i are independent and may coincide with each other and with any grant.
REQ-032 tlp_valid_o never depends combinationally on tlp_ready_i.

Reset
REQ-033 On rst: state EMPTY, tlp_valid_o=0, tlp_o=0, tlp_src_o=0, p_ready_o=np_ready_o=0, ph_cnt=PH_CREDITS, nph_cnt=NPH_CREDITS, cred_err_o=0, pointer=NP.
REQ-034 Reset mid-transfer discards the held TLP; no ready pulse in the cycle rst is high.

Verification
REQ-035 P and NP both valid from reset, tlp_ready_i=1 -> tlp_src_o sequence 0,1,0,1 on consecutive cycles; ph_cnt_o and nph_cnt_o each 6 after four transfers.
REQ-036 tlp_ready_i=0 for 5 cycles with FULL -> tlp_o stable, no ready pulses, counters unchanged; ready rises -> next TLP the following cycle.
REQ-037 PH_CREDITS=2, only P valid, no returns -> exactly 2 grants, then p_ready_o stays 0; one ph_ret_i -> one more grant 1 cycle later.
REQ-038 nph_cnt=0 with both valid -> P granted every cycle, NP starved until nph_ret_i, then NP wins the next tie.
REQ-039 ph_ret_i at ph_cnt=PH_CREDITS -> cred_err_o=1, ph_cnt_o unchanged; grant plus return same cycle -> counter unchanged.
REQ-040 rst asserted while FULL with tlp_ready_i=0 -> tlp_valid_o=0 immediately, counters back to init values.

Source files
------------

// File: rtl/urp_pcie_tx_arbiter.sv
// Transmit arbiter for PCIe posted/non-posted TLPs: round-robin between two
// header-credit-gated sources feeding a single output register.
module urp_pcie_tx_arbiter #(
  parameter int unsigned PH_CREDITS  = 8,
  parameter int unsigned NPH_CREDITS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [223:0] p_tlp_i,
  input  logic         p_valid_i,
  output logic         p_ready_o,
  input  logic [223:0] np_tlp_i,
  input  logic         np_valid_i,
  output logic         np_ready_o,
  input  logic         ph_ret_i,
  input  logic         nph_ret_i,
  output logic [223:0] tlp_o,
  output logic         tlp_valid_o,
  input  logic         tlp_ready_i,
  output logic         tlp_src_o,
  output logic [7:0]   ph_cnt_o,
  output logic [7:0]   nph_cnt_o,
  output logic         cred_err_o,
  output logic         dbg_state_o
);

  // Handshakes: a source TLP moves when its *_valid_i and *_ready_o are both 1
  // in the same cycle; tlp_o moves when tlp_valid_o and tlp_ready_i are both 1.
  // Ready outputs may depend on valid inputs; tlp_valid_o is purely registered.

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic [7:0] PH_INIT  = 8'(PH_CREDITS);
  localparam logic [7:0] NPH_INIT = 8'(NPH_CREDITS);

  state_t       state_q, state_d;
  logic [223:0] tlp_q, tlp_d;
  logic         src_q, src_d;
  logic         last_np_q, last_np_d;
  logic [7:0]   ph_cnt_q, ph_cnt_d;
  logic [7:0]   nph_cnt_q, nph_cnt_d;
  logic         err_q, err_d;

  logic p_elig, np_elig, load_ok, grant_p, grant_np;

  always_comb begin
    state_d   = state_q;
    tlp_d     = tlp_q;
    src_d     = src_q;
    last_np_d = last_np_q;
    ph_cnt_d  = ph_cnt_q;
    nph_cnt_d = nph_cnt_q;
    err_d     = err_q;

    p_elig   = p_valid_i && (ph_cnt_q != 8'd0);
    np_elig  = np_valid_i && (nph_cnt_q != 8'd0);
    load_ok  = (state_q == ST_EMPTY) || tlp_ready_i;
    // On a tie the pointer picks the class not served last.
    grant_p  = !rst && load_ok && p_elig && (!np_elig || last_np_q);
    grant_np = !rst && load_ok && np_elig && !grant_p;

    if (load_ok) begin
      state_d = (grant_p || grant_np) ? ST_FULL : ST_EMPTY;
    end
    if (grant_p) begin
      tlp_d     = p_tlp_i;
      src_d     = 1'b0;
      last_np_d = 1'b0;
    end else if (grant_np) begin
      tlp_d     = np_tlp_i;
      src_d     = 1'b1;
      last_np_d = 1'b1;
    end

    case ({grant_p, ph_ret_i})
      2'b10: ph_cnt_d = ph_cnt_q - 8'd1;
      2'b01: begin
        if (ph_cnt_q == PH_INIT) err_d = 1'b1;
        else                     ph_cnt_d = ph_cnt_q + 8'd1;
      end
      default: ph_cnt_d = ph_cnt_q;
    endcase

    case ({grant_np, nph_ret_i})
      2'b10: nph_cnt_d = nph_cnt_q - 8'd1;
      2'b01: begin
        if (nph_cnt_q == NPH_INIT) err_d = 1'b1;
        else                       nph_cnt_d = nph_cnt_q + 8'd1;
      end
      default: nph_cnt_d = nph_cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      tlp_q     <= '0;
      src_q     <= 1'b0;
      last_np_q <= 1'b1;
      ph_cnt_q  <= PH_INIT;
      nph_cnt_q <= NPH_INIT;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tlp_q     <= tlp_d;
      src_q     <= src_d;
      last_np_q <= last_np_d;
      ph_cnt_q  <= ph_cnt_d;
      nph_cnt_q <= nph_cnt_d;
      err_q     <= err_d;
    end
  end

  assign p_ready_o   = grant_p;
  assign np_ready_o  = grant_np;
  assign tlp_o       = tlp_q;
  assign tlp_valid_o = (state_q == ST_FULL);
  assign tlp_src_o   = src_q;
  assign ph_cnt_o    = ph_cnt_q;
  assign nph_cnt_o   = nph_cnt_q;
  assign cred_err_o  = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_urp_pcie_tx_arbiter.sv
// Randomized and directed bench for urp_pcie_tx_arbiter with a credit/arbitration
// reference model and a queue of expected output TLPs.
module tb_urp_pcie_tx_arbiter;
  localparam int PH  = 8;
  localparam int NPH = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [223:0] p_tlp_i, np_tlp_i, tlp_o;
  logic p_valid_i, np_valid_i, p_ready_o, np_ready_o;
  logic ph_ret_i, nph_ret_i, tlp_valid_o, tlp_ready_i, tlp_src_o;
  logic [7:0] ph_cnt_o, nph_cnt_o;
  logic cred_err_o, dbg_state_o;

  urp_pcie_tx_arbiter #(.PH_CREDITS(PH), .NPH_CREDITS(NPH)) dut (
    .clk(clk), .rst(rst),
    .p_tlp_i(p_tlp_i), .p_valid_i(p_valid_i), .p_ready_o(p_ready_o),
    .np_tlp_i(np_tlp_i), .np_valid_i(np_valid_i), .np_ready_o(np_ready_o),
    .ph_ret_i(ph_ret_i), .nph_ret_i(nph_ret_i),
    .tlp_o(tlp_o), .tlp_valid_o(tlp_valid_o), .tlp_ready_i(tlp_ready_i),
    .tlp_src_o(tlp_src_o), .ph_cnt_o(ph_cnt_o), .nph_cnt_o(nph_cnt_o),
    .cred_err_o(cred_err_o), .dbg_state_o(dbg_state_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [224:0] exp_q[$];   // {src, tlp} of each granted TLP, in output order
  int m_ph, m_nph;
  bit m_full, m_last_np, m_err;

  always @(negedge clk) begin
    bit pe, ne, load_ok, gp, gnp;
    if (rst) begin
      check("rst_p_ready", 256'(p_ready_o), 256'(0));
      check("rst_np_ready", 256'(np_ready_o), 256'(0));
      check("rst_valid", 256'(tlp_valid_o), 256'(0));
      check("rst_tlp", 256'(tlp_o), 256'(0));
      check("rst_src", 256'(tlp_src_o), 256'(0));
      check("rst_ph", 256'(ph_cnt_o), 256'(PH));
      check("rst_nph", 256'(nph_cnt_o), 256'(NPH));
      check("rst_err", 256'(cred_err_o), 256'(0));
      m_ph = PH; m_nph = NPH;
      m_full = 0; m_last_np = 1; m_err = 0;
      exp_q.delete();
    end else begin
      pe = p_valid_i && (m_ph > 0);
      ne = np_valid_i && (m_nph > 0);
      load_ok = !m_full || tlp_ready_i;
      gp = 0; gnp = 0;
      if (load_ok) begin
        if (pe && ne) begin
          gp = m_last_np; gnp = !m_last_np;
        end else begin
          gp = pe; gnp = ne;
        end
      end
      check("p_ready", 256'(p_ready_o), 256'(gp));
      check("np_ready", 256'(np_ready_o), 256'(gnp));
      check("valid", 256'(tlp_valid_o), 256'(m_full));
      check("ph_cnt", 256'(ph_cnt_o), 256'(m_ph));
      check("nph_cnt", 256'(nph_cnt_o), 256'(m_nph));
      check("cred_err", 256'(cred_err_o), 256'(m_err));
      if (gp) begin
        exp_q.push_back({1'b0, p_tlp_i});
        m_last_np = 0;
      end
      if (gnp) begin
        exp_q.push_back({1'b1, np_tlp_i});
        m_last_np = 1;
      end
      if (load_ok) m_full = gp || gnp;
      // Available credits can never exceed what the partner granted at init.
      if (ph_ret_i && !gp && m_ph == PH) m_err = 1;
      else m_ph = m_ph - (gp ? 1 : 0) + (ph_ret_i ? 1 : 0);
      if (nph_ret_i && !gnp && m_nph == NPH) m_err = 1;
      else m_nph = m_nph - (gnp ? 1 : 0) + (nph_ret_i ? 1 : 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [224:0] e;
    if (!rst && tlp_valid_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_tlp", 256'(1), 256'(0));
      end else begin
        e = exp_q[0];
        check("tlp_src", 256'(tlp_src_o), 256'(e[224]));
        check("tlp_data", 256'(tlp_o), 256'(e[223:0]));
        if (tlp_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  function automatic logic [223:0] rand224();
    logic [223:0] r;
    for (int i = 0; i < 7; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive(input bit pv, input bit nv, input bit rdy, input bit pr, input bit nr);
    @(posedge clk); #1;
    p_valid_i = pv; np_valid_i = nv; tlp_ready_i = rdy;
    ph_ret_i = pr; nph_ret_i = nr;
    p_tlp_i = rand224(); np_tlp_i = rand224();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    p_valid_i = 0; np_valid_i = 0; tlp_ready_i = 0; ph_ret_i = 0; nph_ret_i = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    p_valid_i = 0; np_valid_i = 0; tlp_ready_i = 0; ph_ret_i = 0; nph_ret_i = 0;
    p_tlp_i = '0; np_tlp_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Alternating ties from reset: P first, then NP, P, NP.
    repeat (4) drive(1, 1, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    @(negedge clk);
    check("ph_after4", 256'(ph_cnt_o), 256'(6));
    check("nph_after4", 256'(nph_cnt_o), 256'(6));

    // Output stall for 5 cycles, then release.
    drive(1, 1, 1, 0, 0);
    repeat (5) drive(1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0);
    drive(0, 0, 1, 0, 0);

    // Grant plus return in one cycle, then return at init value.
    do_reset();
    drive(1, 0, 1, 1, 0);
    drive(0, 0, 1, 1, 0);
    drive(0, 0, 1, 0, 0);
    @(negedge clk);
    check("err_sticky", 256'(cred_err_o), 256'(1));
    check("ph_at_init", 256'(ph_cnt_o), 256'(PH));

    // Drain posted credits, then one return re-enables a single grant.
    do_reset();
    repeat (PH + 3) drive(1, 0, 1, 0, 0);
    @(negedge clk);
    check("ph_drained", 256'(ph_cnt_o), 256'(0));
    drive(1, 0, 1, 1, 0);
    repeat (3) drive(1, 0, 1, 0, 0);

    // NP starved at zero credits, then wins the next tie after a return.
    do_reset();
    repeat (NPH) drive(0, 1, 1, 0, 0);
    repeat (5) drive(1, 1, 1, 0, 0);
    drive(1, 1, 1, 0, 1);
    repeat (3) drive(1, 1, 1, 0, 0);

    // Randomized traffic with occasional reset.
    do_reset();
    repeat (2000) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    // Reset while holding a stalled TLP.
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst_midxfer_valid", 256'(tlp_valid_o), 256'(0));
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) drive(1, 1, 1, 0, 0);
    repeat (3) drive(0, 0, 1, 0, 0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
